// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED display definitions: mode codes, scan direction, gray helper
// Purpose : constants and helpers shared by the LED display blocks.
// Contents: MODE_* pattern selectors, dir_t scan/breathe direction,
//           bin2gray() for up to MAX_LEDS bits (callers truncate to their width).
package led_pkg;

  localparam logic [1:0] MODE_BIN     = 2'd0;
  localparam logic [1:0] MODE_GRAY    = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam int MAX_LEDS = 32;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic [MAX_LEDS-1:0] bin2gray(input logic [MAX_LEDS-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running prescaler producing pattern ticks and PWM phase
// Purpose : WIDTH-bit wrapping up-counter; raw_tick marks the last count of each period,
//           pwm_phase is the low PWM_BITS of the count used as the breathe comparator ramp.
// Ports   : clk       in  system clock
//           rst       in  synchronous active-high reset
//           raw_tick  out high while the counter is all-ones (combinational)
//           pwm_phase out low PWM_BITS bits of the counter
module led_prescaler #(
  parameter int WIDTH    = 22,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                raw_tick,
  output logic [PWM_BITS-1:0] pwm_phase
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign raw_tick  = &count;
  assign pwm_phase = count[PWM_BITS-1:0];

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - runtime-selectable LED pattern engine
// Purpose : advances one of binary / gray / bounce-scanner / PWM-breathe patterns on each
//           prescaler tick, with pause and single-step control.
// Ports   : clk   in  system clock
//           rst   in  synchronous active-high reset
//           mode  in  pattern select, sampled only at a pattern advance
//           pause in  level, freezes the pattern (prescaler keeps running)
//           step  in  one-cycle pulse, forces one advance while paused
//           led   out registered LED drive, bit0 = LED1
//           tick  out registered one-cycle strobe at every pattern advance
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NLEDS     = 8,
  parameter int LOG2DELAY = 22,
  parameter int PWM_BITS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic             step,
  output logic [NLEDS-1:0] led,
  output logic             tick
);

  localparam int                  IDXW     = $clog2(NLEDS);
  localparam logic [IDXW-1:0]     IDX_MAX  = IDXW'(NLEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic                raw_tick;
  logic [PWM_BITS-1:0] pwm_phase;

  logic [1:0]          mode_q;
  logic [NLEDS-1:0]    cnt;
  logic [IDXW-1:0]     idx;
  dir_t                scan_dir;
  logic [PWM_BITS-1:0] duty;
  dir_t                duty_dir;
  logic [NLEDS-1:0]    led_next;

  logic adv, restart, advance;

  led_prescaler #(
    .WIDTH   (LOG2DELAY),
    .PWM_BITS(PWM_BITS)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .raw_tick (raw_tick),
    .pwm_phase(pwm_phase)
  );

  // A tick arriving while paused is dropped; step only counts while paused,
  // so a coincident tick+step yields a single advance.
  assign adv     = (raw_tick & ~pause) | (step & pause);
  // A mode change consumes the advance to restart the new pattern at zero.
  assign restart = adv && (mode != mode_q);
  assign advance = adv && !restart;

  // Mode register, shared binary/gray counter and tick strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_BIN;
      cnt    <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= adv;
      if (restart) begin
        mode_q <= mode;
        cnt    <= '0;
      end else if (advance && (mode_q == MODE_BIN || mode_q == MODE_GRAY)) begin
        cnt <= cnt + NLEDS'(1);
      end
    end
  end

  // Bounce scanner: turning at an endpoint moves straight off it so each end is lit once.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      idx      <= '0;
      scan_dir <= DIR_UP;
    end else if (advance && mode_q == MODE_SCAN) begin
      if (scan_dir == DIR_UP) begin
        if (idx == IDX_MAX) begin
          scan_dir <= DIR_DOWN;
          idx      <= idx - IDXW'(1);
        end else begin
          idx <= idx + IDXW'(1);
        end
      end else begin
        if (idx == '0) begin
          scan_dir <= DIR_UP;
          idx      <= idx + IDXW'(1);
        end else begin
          idx <= idx - IDXW'(1);
        end
      end
    end
  end

  // Breathe: triangle duty ramp between 0 and DUTY_MAX.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      duty     <= '0;
      duty_dir <= DIR_UP;
    end else if (advance && mode_q == MODE_BREATHE) begin
      if (duty_dir == DIR_UP) begin
        if (duty == DUTY_MAX) begin
          duty_dir <= DIR_DOWN;
          duty     <= duty - PWM_BITS'(1);
        end else begin
          duty <= duty + PWM_BITS'(1);
        end
      end else begin
        if (duty == '0) begin
          duty_dir <= DIR_UP;
          duty     <= duty + PWM_BITS'(1);
        end else begin
          duty <= duty - PWM_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    led_next = '0;
    case (mode_q)
      MODE_BIN:     led_next = cnt;
      MODE_GRAY:    led_next = NLEDS'(bin2gray(MAX_LEDS'(cnt)));
      MODE_SCAN:    led_next = NLEDS'(1) << idx;
      MODE_BREATHE: led_next = {NLEDS{pwm_phase < duty}};
      default:      led_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  localparam int NL   = 8;
  localparam int PER  = 16;
  localparam int DMAX = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          pause = 1'b0;
  logic          step = 1'b0;
  logic [NL-1:0] led;
  logic          tick;

  led_pattern_gen #(
    .NLEDS    (NL),
    .LOG2DELAY(4),
    .PWM_BITS (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pause(pause),
    .step (step),
    .led  (led),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pattern position n counts advances since the last restart.
  int       m_pre  = 0;
  int       m_mode = 0;
  int       m_n    = 0;
  logic     m_tick = 1'b0;
  logic [7:0] m_led = 8'h00;
  bit       primed = 0;

  function automatic logic [7:0] led_of(input int md, input int n, input int pre);
    int p, d;
    case (md)
      0: return 8'(n % 256);
      1: begin
        p = n % 256;
        return 8'(p ^ (p >> 1));
      end
      2: begin
        p = n % (2 * NL - 2);
        return 8'(1 << ((p < NL) ? p : (2 * NL - 2 - p)));
      end
      default: begin
        p = n % (2 * DMAX);
        d = (p <= DMAX) ? p : (2 * DMAX - p);
        return ((pre % 8) < d) ? 8'hFF : 8'h00;
      end
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] md, input logic p, input logic s);
    logic adv;
    if (r) begin
      m_pre = 0; m_n = 0; m_mode = 0; m_led = 8'h00; m_tick = 1'b0;
    end else begin
      m_led  = led_of(m_mode, m_n, m_pre);
      adv    = p ? s : (m_pre == PER - 1);
      m_tick = adv;
      if (adv) begin
        if (int'(md) != m_mode) begin
          m_mode = int'(md);
          m_n    = 0;
        end else begin
          m_n++;
        end
      end
      m_pre = (m_pre + 1) % PER;
    end
  endtask

  // One clock: check outputs of the previous edge, then drive inputs for the next edge.
  task automatic cyc(input logic r, input logic [1:0] md, input logic p, input logic s);
    @(negedge clk);
    if (primed) begin
      check("led", {24'b0, led}, {24'b0, m_led});
      check("tick", {31'b0, tick}, {31'b0, m_tick});
    end
    rst = r; mode = md; pause = p; step = s;
    model_edge(r, md, p, s);
    primed = 1;
  endtask

  logic [7:0] got_q[$];
  logic [7:0] gray_exp [7]  = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};
  logic [7:0] scan_exp [17] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    logic [1:0] md;
    logic       ps, st, rs;

    // Reset with gray selected, then capture led one cycle after each tick.
    repeat (3) cyc(1'b1, 2'd1, 1'b0, 1'b0);
    for (int c = 0; c < 400 && got_q.size() < 7; c++) begin
      cyc(1'b0, 2'd1, 1'b0, 1'b0);
      if (tick === 1'b1) begin
        cyc(1'b0, 2'd1, 1'b0, 1'b0);
        got_q.push_back(led);
      end
    end
    check("gray_count", got_q.size(), 7);
    for (int i = 0; i < got_q.size() && i < 7; i++) check("gray_seq", {24'b0, got_q[i]}, {24'b0, gray_exp[i]});

    // Switch to scanner mid-period; first advance restarts at LED1.
    got_q.delete();
    for (int c = 0; c < 900 && got_q.size() < 17; c++) begin
      cyc(1'b0, 2'd2, 1'b0, 1'b0);
      if (tick === 1'b1) begin
        cyc(1'b0, 2'd2, 1'b0, 1'b0);
        got_q.push_back(led);
      end
    end
    check("scan_count", got_q.size(), 17);
    for (int i = 0; i < got_q.size() && i < 17; i++) check("scan_seq", {24'b0, got_q[i]}, {24'b0, scan_exp[i]});

    // Binary through a full 8-bit wrap.
    repeat (PER * 260) cyc(1'b0, 2'd0, 1'b0, 1'b0);

    // Breathe through more than one triangle.
    repeat (PER * 20) cyc(1'b0, 2'd3, 1'b0, 1'b0);

    // Pause for 5 periods, then a step coincident with the raw tick.
    repeat (PER * 5) cyc(1'b0, 2'd3, 1'b1, 1'b0);
    for (int c = 0; c < 2 * PER && m_pre != PER - 1; c++) cyc(1'b0, 2'd3, 1'b1, 1'b0);
    cyc(1'b0, 2'd3, 1'b1, 1'b1);
    repeat (5) cyc(1'b0, 2'd3, 1'b1, 1'b0);
    cyc(1'b0, 2'd3, 1'b1, 1'b1);
    repeat (PER * 2) cyc(1'b0, 2'd3, 1'b0, 1'b0);

    // Reset on the same edge as an advance.
    for (int c = 0; c < 2 * PER && m_pre != PER - 1; c++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    repeat (PER * 3) cyc(1'b0, 2'd0, 1'b0, 1'b0);

    // Randomized stimulus against the model.
    md = 2'd0; ps = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(63) == 0) md = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) ps = ~ps;
      st = (!step && $urandom_range(9) == 0);
      rs = ($urandom_range(1999) == 0);
      cyc(rs, md, ps, st);
    end
    cyc(1'b0, md, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
